// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the FIR output path: sample widths, FSM encoding,
// and the rounding/saturation helpers used by the scaling stages.
package dsp_pkg;

  localparam int FIR_Y_W = 16;

  // Wide enough that rounding and range checks on any FIR sample never wrap.
  typedef logic signed [31:0] acc_t;

  typedef enum logic {ST_FILL, ST_RUN} state_e;

  // Arithmetic right shift with round-half-up; sh == 0 passes x through.
  function automatic acc_t round_shift(input acc_t x, input int sh);
    if (sh <= 0) return x;
    return (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp x to the signed range of a w-bit value.
  function automatic acc_t sat_to(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fir_decim_sink_if.sv
// Sample stream in from the FIR and valid/ready result stream out to the consumer.
interface fir_decim_sink_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head. The head appears one cycle after
// the write into an empty FIFO; push and pop together while full is accepted.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          push_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign push_ok = push && (!full || pop);

  // pop is only issued by the owner while the head is valid (!empty).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    count_d    = count_q + LW'(push_ok) - LW'(pop);
    // Head is valid next cycle only for entries already stored before this edge.
    rd_valid_d = count_q > LW'(pop);
    rd_data_d  = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign empty   = !rd_valid_q;
  assign level   = count_q;

endmodule

// File: rtl/fir_decim_sink.sv
// FIR output stage: drops the start-up transient, decimates, rounds/shifts,
// saturates and queues results for a valid/ready consumer.
module fir_decim_sink
  import dsp_pkg::*;
#(
  parameter  int IN_W  = FIR_Y_W,
  parameter  int OUT_W = 8,
  parameter  int SHIFT = 2,
  parameter  int DECIM = 4,
  parameter  int FILL  = 3,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  fir_decim_sink_if.slave  bus,
  input  logic             clr_flags,
  output logic [LW-1:0]    level,
  output logic             sat_flag,
  output logic             overflow
);

  localparam int     FCW       = (FILL > 1) ? $clog2(FILL) : 1;
  localparam int     PW        = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam state_e RST_STATE = (FILL == 0) ? ST_RUN : ST_FILL;

  state_e                  state_q, state_d;
  logic [FCW-1:0]          fill_cnt_q, fill_cnt_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    keep;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [IN_W:0]    s1_data_q, s1_data_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [OUT_W-1:0] s2_data_q, s2_data_d;
  acc_t                    s1_ext;
  logic                    sat_evt;

  logic                    sat_flag_q, sat_flag_d;
  logic                    overflow_q, overflow_d;

  logic                    fifo_full, fifo_empty, pop, ovf_evt;
  logic [OUT_W-1:0]        fifo_rd_data;

  // Transient discard, then keep the sample at phase 0 of every DECIM.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    phase_d    = phase_q;
    keep       = 1'b0;
    if (bus.in_valid) begin
      if (state_q == ST_FILL) begin
        if (fill_cnt_q == FCW'(FILL - 1)) begin
          state_d    = ST_RUN;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + FCW'(1);
        end
      end else begin
        keep    = (phase_q == '0);
        phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = keep;
    s1_data_d  = (IN_W + 1)'(round_shift(acc_t'(bus.in_data), SHIFT));
    s1_ext     = acc_t'(s1_data_q);
    sat_evt    = s1_valid_q && (sat_to(s1_ext, OUT_W) != s1_ext);
    s2_valid_d = s1_valid_q;
    s2_data_d  = OUT_W'(sat_to(s1_ext, OUT_W));
    pop        = !fifo_empty && bus.out_ready;
    ovf_evt    = s2_valid_q && fifo_full && !pop;
    // A new event beats a coincident clear.
    sat_flag_d = sat_evt || (sat_flag_q && !clr_flags);
    overflow_d = ovf_evt || (overflow_q && !clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RST_STATE;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_flag_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      sat_flag_q <= sat_flag_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (s2_valid_q),
    .wr_data (s2_data_q),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_rd_data;
  assign sat_flag      = sat_flag_q;
  assign overflow      = overflow_q;

endmodule
